data_mem_responder: RTL and testbench

Multi-cycle data-memory responder serving the MEM stage of the 5-stage pipeline. It accepts one load or store per handshake, inserts a programmable number of wait states, then commits the write or returns read data with a one-cycle completion pulse. It sits where the single-cycle data memory sits today. The pipeline uses `busy` to stall and `done` to advance.

---
 rtl/mem_resp_pkg.sv | 32 +++
 rtl/mem_resp_array.sv | 35 +++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_resp_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_RD,
      OP_WR,
      OP_BAD
   } op_e;

   // Load and store requested together cannot be served; it is tagged here and
   // reported through err when the access would have happened.
   function automatic op_e decode_op(input logic rd_req, input logic wr_req);
      op_e op;
      if (rd_req && wr_req) begin
         op = OP_BAD;
      end else if (wr_req) begin
         op = OP_WR;
      end else begin
         op = OP_RD;
      end
      return op;
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word storage; write and read both take effect on the edge.
module mem_resp_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Contents survive reset; only the returned-data register is cleared.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one access per handshake, WAIT_CYCLES wait
// states, then a one-cycle done pulse. Holds FSM, request latches and checks.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   op_e                op_q, op_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wd_q, wd_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               req;
   logic               access;
   logic               addr_ok;
   logic               mem_we;
   logic               mem_re;

   assign req     = MemRead | MemWrite;
   assign access  = (state_q == BUSY) && (cnt_q == '0);
   // Word aligned and no address bits set above the word index.
   assign addr_ok = (addr_q[1:0] == 2'b00) && (addr_q[31:IDX_W+2] == '0);
   assign mem_we  = access && (op_q == OP_WR) && addr_ok;
   assign mem_re  = access && (op_q == OP_RD) && addr_ok;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               op_d    = decode_op(MemRead, MemWrite);
               addr_d  = addr;
               wd_d    = wd;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
               if ((op_q == OP_BAD) || !addr_ok) begin
                  err_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   mem_resp_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .idx_i   (addr_q[IDX_W+1:2]),
      .wdata_i (wd_q),
      .rdata_o (rd)
   );

   // Combinational so the pipeline stalls in the request cycle itself.
   assign busy = (state_q == BUSY) || ((state_q == IDLE) && req);
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (W=2, W=0, W=3) driven by vector tables
// and hand sequences; expected results flow through a scoreboard queue.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        mr  [3];
   logic        mw  [3];
   logic [31:0] ad  [3];
   logic [31:0] wdv [3];
   logic [31:0] rdv [3];
   logic        bz  [3];
   logic        dn  [3];
   logic        er  [3];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] rd;
      bit          err;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      bit          rst_before;
      bit          r;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] erd;
      bit          eerr;
   } vec_t;
   vec_t tbl[11];

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
      .wd(wdv[0]), .rd(rdv[0]), .busy(bz[0]), .done(dn[0]), .err(er[0]));

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
      .wd(wdv[1]), .rd(rdv[1]), .busy(bz[1]), .done(dn[1]), .err(er[1]));

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst), .MemRead(mr[2]), .MemWrite(mw[2]), .addr(ad[2]),
      .wd(wdv[2]), .rd(rdv[2]), .busy(bz[2]), .done(dn[2]), .err(er[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wait_of(input int k);
      int w;
      case (k)
         0:       w = 2;
         1:       w = 0;
         default: w = 3;
      endcase
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Asserted between edges; outputs must clear without waiting for a clock.
   task automatic rst_pulse();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_rd", rdv[k], 32'h0);
         chk("rst_done", 32'(dn[k]), 32'h0);
         chk("rst_err", 32'(er[k]), 32'h0);
         chk("rst_busy", 32'(bz[k]), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic xact(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd, input bit eerr);
      exp_t e;
      int   nb;
      bit   got;
      sbq.push_back('{rd: erd, err: eerr});
      @(negedge clk);
      mr[k] = r; mw[k] = w; ad[k] = a; wdv[k] = d;
      #1 chk("busy_req", 32'(bz[k]), 32'h1);
      @(negedge clk);
      mr[k] = 1'b0; mw[k] = 1'b0;
      nb  = 0;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (dn[k]) begin
            got = 1'b1;
            break;
         end
         if (bz[k]) nb++;
         @(negedge clk);
      end
      chk("done_seen", 32'(got), 32'h1);
      chk("busy_cycles", 32'(nb), 32'(wait_of(k) + 1));
      e = sbq.pop_front();
      if (got) begin
         chk("rd", rdv[k], e.rd);
         chk("err", 32'(er[k]), 32'(e.err));
         chk("busy_in_done", 32'(bz[k]), 32'h0);
         @(negedge clk);
         chk("done_pulse_len", 32'(dn[k]), 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   idx;
      int   cyc;
      int   last;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wdv[k] = '0;
      end
      #7 rst = 1'b1;
      #1;
      chk("init_rst_rd", rdv[0], 32'h0);
      chk("init_rst_done", 32'(dn[0]), 32'h0);
      chk("init_rst_err", 32'(er[0]), 32'h0);
      chk("init_rst_busy", 32'(bz[0]), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // W=0: preload 1,2,3 then hold MemRead across three accesses.
      xact(1, 1'b0, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0);
      xact(1, 1'b0, 1'b1, 32'h4, 32'h2, 32'h0, 1'b0);
      xact(1, 1'b0, 1'b1, 32'h8, 32'h3, 32'h0, 1'b0);
      for (int i = 1; i <= 3; i++) sbq.push_back('{rd: 32'(i), err: 1'b0});
      @(negedge clk);
      mr[1] = 1'b1; ad[1] = 32'h0;
      idx = 0; cyc = 0; last = 0;
      for (int c = 0; c < 60 && idx < 3; c++) begin
         @(negedge clk);
         cyc++;
         if (dn[1]) begin
            e = sbq.pop_front();
            chk("b2b_rd", rdv[1], e.rd);
            // IDLE, BUSY and DONE each last one cycle when W=0.
            if (idx > 0) chk("b2b_interval", 32'(cyc - last), 32'h3);
            last = cyc;
            idx++;
            if (idx < 3) ad[1] = 32'(idx * 4);
            else mr[1] = 1'b0;
         end
      end
      chk("b2b_count", 32'(idx), 32'h3);
      mr[1] = 1'b0;

      // W=3: reset during BUSY discards the pending store.
      xact(2, 1'b0, 1'b1, 32'h8, 32'h77, 32'h0, 1'b0);
      @(negedge clk);
      mw[2] = 1'b1; ad[2] = 32'h8; wdv[2] = 32'h5;
      @(negedge clk);
      mw[2] = 1'b0;
      chk("mid_busy", 32'(bz[2]), 32'h1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bz[2]), 32'h0);
      chk("mid_rst_done", 32'(dn[2]), 32'h0);
      chk("mid_rst_rd", rdv[2], 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("mid_no_done", 32'(dn[2]), 32'h0);
      end
      xact(2, 1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 1'b0);

      // W=2 vector table.
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h20,  32'h12345678, 32'hCAFEF00D, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h20,  32'hFFFFFFFF, 32'hCAFEF00D, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h13,  32'hAAAAAAAA, 32'h0,        1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].rst_before) rst_pulse();
         xact(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].erd, tbl[i].eerr);
      end

      chk("sb_empty", 32'(sbq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
